// File: rtl/sigmoid_backward.sv
// Sigmoid backward pass: grad_out = grad_in * s * (1 - s), one shared add_sub and multiplier.
// Optional SIGMOID_BWD_BYPASS_EN: s == +0.0 or s == 1.0 short-circuits straight to DONE.

// Normalise, round and pack a significand/exponent pair into an FP word.
module sigmoid_backward_round #(
    parameter int E = 8,
    parameter int M = 24
) (
    input  logic                sign,
    input  logic signed [E+2:0] exp_in,
    input  logic [M+2:0]        man_in,
    input  logic [2:0]          rm,
    output logic [E+M-1:0]      res,
    output logic [4:0]          flags
);
    localparam int MW = M + 3;
    localparam int XW = E + 3;
    localparam int F  = M - 1;
    localparam logic signed [XW-1:0] X_ONE  = XW'(1);
    localparam logic signed [XW-1:0] X_EMAX = XW'((1 << E) - 1);
    localparam logic signed [XW-1:0] X_MW   = XW'(MW);

    logic signed [XW-1:0] lz;
    logic signed [XW-1:0] e;
    logic signed [XW-1:0] rs;
    logic [MW-1:0]        man_n;
    logic [M-1:0]         keep;
    logic [M:0]           rnd;
    logic [M-1:0]         frac_o;
    logic                 gb;
    logic                 st;
    logic                 ix;
    logic                 inc;
    logic                 odd;
    logic                 tiny;
    logic                 ovf_inf;

    function automatic logic [XW-1:0] lzc(input logic [MW-1:0] v);
        logic [XW-1:0] n;
        logic          hit;
        n   = '0;
        hit = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!hit && !v[i]) n = n + XW'(1);
            else hit = 1'b1;
        end
        return n;
    endfunction

    // Normalise (or denormalise into the subnormal range), then round per rm.
    always_comb begin
        lz      = $signed(lzc(man_in));
        e       = X_ONE;
        rs      = '0;
        man_n   = '0;
        keep    = '0;
        rnd     = '0;
        frac_o  = '0;
        gb      = 1'b0;
        st      = 1'b0;
        ix      = 1'b0;
        inc     = 1'b0;
        odd     = 1'b0;
        tiny    = 1'b0;
        ovf_inf = 1'b1;
        res     = {sign, {(E+M-1){1'b0}}};
        flags   = '0;
        if (man_in != '0) begin
            if (exp_in - lz >= X_ONE) begin
                man_n = man_in << lz;
                e     = exp_in - lz;
            end else if (exp_in >= X_ONE) begin
                man_n = man_in << (exp_in - X_ONE);
                e     = X_ONE;
            end else begin
                rs = X_ONE - exp_in;
                if (rs > X_MW) rs = X_MW;
                man_n    = man_in >> rs;
                man_n[0] = man_n[0] | (|(man_in & ~({MW{1'b1}} << rs)));
                e        = X_ONE;
            end
            tiny = !man_n[MW-1];
            keep = man_n[MW-1:3];
            gb   = man_n[2];
            st   = |man_n[1:0];
            ix   = gb | st;
            case (rm)
                3'd1: inc = 1'b0;
                3'd2: inc = sign & ix;
                3'd3: inc = ~sign & ix;
                3'd4: inc = gb;
                3'd6: odd = 1'b1;
                default: inc = gb & (st | keep[0]);
            endcase
            if (odd) keep[0] = keep[0] | ix;
            rnd = {1'b0, keep} + {{M{1'b0}}, inc};
            if (rnd[M]) begin
                frac_o = rnd[M:1];
                e      = e + X_ONE;
            end else begin
                frac_o = rnd[M-1:0];
            end
            case (rm)
                3'd1, 3'd6: ovf_inf = 1'b0;
                3'd2:       ovf_inf = sign;
                3'd3:       ovf_inf = ~sign;
                default:    ovf_inf = 1'b1;
            endcase
            if (e >= X_EMAX) begin
                flags = 5'b00101;
                if (ovf_inf) res = {sign, {E{1'b1}}, {F{1'b0}}};
                else res = {sign, {(E-1){1'b1}}, 1'b0, {F{1'b1}}};
            end else begin
                flags = {3'b000, tiny & ix, ix};
                res   = {sign, frac_o[M-1] ? e[E-1:0] : {E{1'b0}}, frac_o[F-1:0]};
            end
        end
    end
endmodule

// Combinational FP add/subtract; op=1 computes a - b.
module sigmoid_backward_addsub #(
    parameter int E = 8,
    parameter int M = 24
) (
    input  logic [E+M-1:0] a,
    input  logic [E+M-1:0] b,
    input  logic           op,
    input  logic [2:0]     rm,
    output logic [E+M-1:0] res,
    output logic [4:0]     flags
);
    localparam int W  = E + M;
    localparam int F  = M - 1;
    localparam int MW = M + 3;
    localparam int XW = E + 3;
    localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};

    logic                 sa, sb;
    logic [E-1:0]         ea, eb;
    logic [F-1:0]         fa, fb;
    logic                 a_nan, b_nan, a_inf, b_inf, any_snan;
    logic                 swap;
    logic                 s_big, s_sml;
    logic [E-1:0]         e_big, e_sml, d;
    logic [M-1:0]         m_big, m_sml;
    logic [MW-1:0]        x_big, x_sml, x_al;
    logic [MW:0]          sum;
    logic                 r_sign;
    logic signed [XW-1:0] r_exp;
    logic [MW-1:0]        r_man;
    logic [W-1:0]         rnd_res;
    logic [4:0]           rnd_flags;
    logic                 special;
    logic [W-1:0]         sp_res;
    logic [4:0]           sp_flags;

    assign sa = a[W-1];
    assign sb = b[W-1] ^ op;
    assign ea = a[W-2:F];
    assign eb = b[W-2:F];
    assign fa = a[F-1:0];
    assign fb = b[F-1:0];
    assign a_nan = (&ea) && (|fa);
    assign b_nan = (&eb) && (|fb);
    assign a_inf = (&ea) && !(|fa);
    assign b_inf = (&eb) && !(|fb);
    assign any_snan = (a_nan && !fa[F-1]) || (b_nan && !fb[F-1]);

    // Align the smaller magnitude to the larger and add or subtract.
    always_comb begin
        swap  = b[W-2:0] > a[W-2:0];
        s_big = swap ? sb : sa;
        s_sml = swap ? sa : sb;
        e_big = swap ? eb : ea;
        e_sml = swap ? ea : eb;
        m_big = {e_big != '0, swap ? fb : fa};
        m_sml = {e_sml != '0, swap ? fa : fb};
        if (e_big == '0) e_big = E'(1);
        if (e_sml == '0) e_sml = E'(1);
        d       = e_big - e_sml;
        x_big   = {m_big, 3'b000};
        x_sml   = {m_sml, 3'b000};
        x_al    = x_sml >> d;
        x_al[0] = x_al[0] | (|(x_sml & ~({MW{1'b1}} << d)));
        if (s_big == s_sml) sum = {1'b0, x_big} + {1'b0, x_al};
        else sum = {1'b0, x_big} - {1'b0, x_al};
        if (sum[MW]) begin
            r_man = {sum[MW:2], sum[1] | sum[0]};
            r_exp = $signed({3'b000, e_big}) + XW'(1);
        end else begin
            r_man = sum[MW-1:0];
            r_exp = $signed({3'b000, e_big});
        end
        r_sign = s_big;
        if (sum == '0) r_sign = (s_big == s_sml) ? s_big : (rm == 3'd2);
    end

    // NaN and infinity operands bypass the rounder.
    always_comb begin
        special  = 1'b1;
        sp_res   = QNAN;
        sp_flags = '0;
        if (a_nan || b_nan) begin
            sp_flags = {any_snan, 4'b0000};
        end else if (a_inf && b_inf && (sa != sb)) begin
            sp_flags = 5'b10000;
        end else if (a_inf) begin
            sp_res = {sa, {E{1'b1}}, {F{1'b0}}};
        end else if (b_inf) begin
            sp_res = {sb, {E{1'b1}}, {F{1'b0}}};
        end else begin
            special = 1'b0;
        end
    end

    sigmoid_backward_round #(.E(E), .M(M)) u_round (
        .sign   (r_sign),
        .exp_in (r_exp),
        .man_in (r_man),
        .rm     (rm),
        .res    (rnd_res),
        .flags  (rnd_flags)
    );

    assign res   = special ? sp_res : rnd_res;
    assign flags = special ? sp_flags : rnd_flags;
endmodule

// Combinational FP multiply.
module sigmoid_backward_mul #(
    parameter int E = 8,
    parameter int M = 24
) (
    input  logic [E+M-1:0] a,
    input  logic [E+M-1:0] b,
    input  logic [2:0]     rm,
    output logic [E+M-1:0] res,
    output logic [4:0]     flags
);
    localparam int W  = E + M;
    localparam int F  = M - 1;
    localparam int MW = M + 3;
    localparam int XW = E + 3;
    localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
    localparam logic signed [XW-1:0] X_BIAS = XW'((1 << (E - 1)) - 1);

    logic                 sx;
    logic [E-1:0]         ea, eb, ea_f, eb_f;
    logic [F-1:0]         fa, fb;
    logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, any_snan;
    logic [2*M-1:0]       p;
    logic signed [XW-1:0] r_exp;
    logic [MW-1:0]        r_man;
    logic [W-1:0]         rnd_res;
    logic [4:0]           rnd_flags;
    logic                 special;
    logic [W-1:0]         sp_res;
    logic [4:0]           sp_flags;

    assign sx = a[W-1] ^ b[W-1];
    assign ea = a[W-2:F];
    assign eb = b[W-2:F];
    assign fa = a[F-1:0];
    assign fb = b[F-1:0];
    assign a_nan  = (&ea) && (|fa);
    assign b_nan  = (&eb) && (|fb);
    assign a_inf  = (&ea) && !(|fa);
    assign b_inf  = (&eb) && !(|fb);
    assign a_zero = (ea == '0) && (fa == '0);
    assign b_zero = (eb == '0) && (fb == '0);
    assign any_snan = (a_nan && !fa[F-1]) || (b_nan && !fb[F-1]);
    assign ea_f = (ea == '0) ? E'(1) : ea;
    assign eb_f = (eb == '0) ? E'(1) : eb;

    // Full product; top MW bits go to the rounder with the rest folded to sticky.
    always_comb begin
        p        = {{M{1'b0}}, ea != '0, fa} * {{M{1'b0}}, eb != '0, fb};
        r_man    = p[2*M-1:M-3];
        r_man[0] = r_man[0] | (|p[M-4:0]);
        r_exp    = $signed({3'b000, ea_f}) + $signed({3'b000, eb_f}) - X_BIAS + XW'(1);
    end

    // NaN, infinity and zero operands bypass the rounder.
    always_comb begin
        special  = 1'b1;
        sp_res   = QNAN;
        sp_flags = '0;
        if (a_nan || b_nan) begin
            sp_flags = {any_snan, 4'b0000};
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            sp_flags = 5'b10000;
        end else if (a_inf || b_inf) begin
            sp_res = {sx, {E{1'b1}}, {F{1'b0}}};
        end else if (a_zero || b_zero) begin
            sp_res = {sx, {(W-1){1'b0}}};
        end else begin
            special = 1'b0;
        end
    end

    sigmoid_backward_round #(.E(E), .M(M)) u_round (
        .sign   (sx),
        .exp_in (r_exp),
        .man_in (r_man),
        .rm     (rm),
        .res    (rnd_res),
        .flags  (rnd_flags)
    );

    assign res   = special ? sp_res : rnd_res;
    assign flags = special ? sp_flags : rnd_flags;
endmodule

// Sequencer: SUB (1-s), MUL1 (s*t), MUL2 (t*g) on shared units, then hold in DONE.
module sigmoid_backward #(
    parameter int exp_width  = 8,
    parameter int mant_width = 24
) (
    input  logic                            clk,
    input  logic                            rst_l,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [exp_width+mant_width-1:0] s_in,
    input  logic [exp_width+mant_width-1:0] grad_in,
    input  logic [2:0]                      round_mode,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [exp_width+mant_width-1:0] grad_out,
    output logic [4:0]                      exceptions
);
    localparam int W = exp_width + mant_width;
    localparam int F = mant_width - 1;
    localparam logic [W-1:0] ONE = {2'b00, {(exp_width-1){1'b1}}, {F{1'b0}}};

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SUB  = 3'd1;
    localparam logic [2:0] MUL1 = 3'd2;
    localparam logic [2:0] MUL2 = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [W-1:0] s_q, s_d;
    logic [W-1:0] g_q, g_d;
    logic [2:0]   rm_q, rm_d;
    logic [W-1:0] t_q, t_d;
    logic [W-1:0] grad_q, grad_d;
    logic [4:0]   flags_q, flags_d;

    logic [W-1:0] add_res, mul_res, mul_a, mul_b;
    logic [4:0]   add_flags, mul_flags;

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign grad_out   = grad_q;
    assign exceptions = flags_q;

    // Multiplier operand select: MUL1 uses (s, 1-s), MUL2 uses (s(1-s), g).
    always_comb begin
        mul_a = (state_q == MUL2) ? t_q : s_q;
        mul_b = (state_q == MUL2) ? g_q : t_q;
    end

    sigmoid_backward_addsub #(.E(exp_width), .M(mant_width)) u_add (
        .a     (ONE),
        .b     (s_q),
        .op    (1'b1),
        .rm    (rm_q),
        .res   (add_res),
        .flags (add_flags)
    );

    sigmoid_backward_mul #(.E(exp_width), .M(mant_width)) u_mul (
        .a     (mul_a),
        .b     (mul_b),
        .rm    (rm_q),
        .res   (mul_res),
        .flags (mul_flags)
    );

    // Next-state and datapath register updates, one unit result per state.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        g_d     = g_q;
        rm_d    = rm_q;
        t_d     = t_q;
        grad_d  = grad_q;
        flags_d = flags_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = s_in;
                    g_d     = grad_in;
                    rm_d    = round_mode;
                    flags_d = '0;
                    state_d = SUB;
`ifdef SIGMOID_BWD_BYPASS_EN
                    if ((s_in == '0) || (s_in == ONE)) begin
                        grad_d  = {grad_in[W-1], {(W-1){1'b0}}};
                        state_d = DONE;
                    end
`endif
                end
            end
            SUB: begin
                t_d     = add_res;
                flags_d = flags_q | add_flags;
                state_d = MUL1;
            end
            MUL1: begin
                t_d     = mul_res;
                flags_d = flags_q | mul_flags;
                state_d = MUL2;
            end
            MUL2: begin
                grad_d  = mul_res;
                flags_d = flags_q | mul_flags;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
            s_q     <= '0;
            g_q     <= '0;
            rm_q    <= '0;
            t_q     <= '0;
            grad_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            g_q     <= g_d;
            rm_q    <= rm_d;
            t_q     <= t_d;
            grad_q  <= grad_d;
            flags_q <= flags_d;
        end
    end
endmodule

// File: tb/tb_sigmoid_backward.sv
// Scoreboard bench for sigmoid_backward: directed vectors plus random ones
// checked against a real-arithmetic reference with per-op single rounding.
module tb_sigmoid_backward;
`ifdef SIGMOID_BWD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] grad;
        logic [4:0]  exc;
        bit          nan;
        int          lat;
        longint      acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] s_in = '0;
    logic [31:0] grad_in = '0;
    logic [2:0]  round_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] grad_out;
    logic [4:0]  exceptions;

    int     n_tests = 0;
    int     n_fail = 0;
    longint cyc = 0;
    bit     ov_prev = 0;
    bit     rand_bp = 0;
    exp_t   sb[$];
    longint acc_log[$];

    sigmoid_backward dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .s_in       (s_in),
        .grad_in    (grad_in),
        .round_mode (round_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .grad_out   (grad_out),
        .exceptions (exceptions)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, req);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Round a double to single (RNE or RTZ); returns {inexact, bits}.
    function automatic logic [32:0] r2f(input real x, input logic [2:0] rm);
        logic [63:0] d;
        logic [30:0] v;
        logic        inc;
        d = $realtobits(x);
        if (d[62:52] == 11'd0) return {1'b0, d[63], 31'd0};
        inc = (rm == 3'd0) && d[28] && ((|d[27:0]) || d[29]);
        v = {8'(d[62:52] - 11'd896), d[51:29]} + {30'd0, inc};
        return {|d[28:0], d[63], v};
    endfunction

    // grad * s * (1 - s) with each of the three operations rounded once.
    function automatic logic [36:0] model(input logic [31:0] s, g, input logic [2:0] rm);
        logic [32:0] t, u, o;
        t = r2f(1.0 - f2r(s), rm);
        u = r2f(f2r(s) * f2r(t[31:0]), rm);
        o = r2f(f2r(u[31:0]) * f2r(g), rm);
        return {4'd0, t[32] | u[32] | o[32], o[31:0]};
    endfunction

    task automatic send(input logic [31:0] s, g, input logic [2:0] rm,
                        input logic [31:0] eg, input logic [4:0] ee,
                        input bit nan, input bit hold);
        exp_t e;
        int   n;
        bit   byp;
        in_valid   = 1'b1;
        s_in       = s;
        grad_in    = g;
        round_mode = rm;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        byp    = BYP && ((s == 32'h0) || (s == 32'h3f800000));
        e.grad = eg;
        e.exc  = ee;
        e.nan  = nan;
        e.lat  = byp ? 0 : 3;
        e.acc  = cyc + 1;
        sb.push_back(e);
        acc_log.push_back(e.acc);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    // Random backpressure, changed just after the edge.
    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom_range(3, 0) != 0);
        end
    end

    // Monitor: latency on each rising out_valid, data on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_l) begin
            ov_prev = 0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) chk("unexpected_output", 64'(grad_out), 64'hx);
                else chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                if (e.nan) chk("grad_is_nan", 64'((&grad_out[30:23]) && (|grad_out[22:0])), 64'd1);
                else chk("grad_out", 64'(grad_out), 64'(e.grad));
                chk("exceptions", 64'(exceptions), 64'(e.exc));
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s, g, held;
        logic [2:0]  rm;
        logic [36:0] m;
        int          n;

        repeat (3) @(posedge clk);
        #1 rst_l = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_grad_out", 64'(grad_out), 64'd0);
        chk("rst_exceptions", 64'(exceptions), 64'd0);
        @(posedge clk);
        #1;

        send(32'h3f000000, 32'h3f800000, 3'd0, 32'h3e800000, 5'd0, 0, 0);
        send(32'h3f400000, 32'h40000000, 3'd0, 32'h3ec00000, 5'd0, 0, 0);
        send(32'h3f800000, 32'hc0400000, 3'd0, 32'h80000000, 5'd0, 0, 0);
        send(32'h00000000, 32'h40000000, 3'd0, 32'h00000000, 5'd0, 0, 0);
        send(32'h3f000000, 32'h3f800000, 3'd1, 32'h3e800000, 5'd0, 0, 0);

        // Backpressure: result held five cycles.
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'h3f400000, 32'h40000000, 3'd0, 32'h3ec00000, 5'd0, 0, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        held = grad_out;
        chk("bp_held_value", 64'(held), 64'h3ec00000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_grad_stable", 64'(grad_out), 64'(held));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_after_in_ready", 64'(in_ready), 64'd1);
        chk("bp_after_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Back-to-back with in_valid held.
        acc_log.delete();
        for (int i = 0; i < 3; i++) begin
            s  = {1'b0, 8'($urandom_range(126, 117)), 23'($urandom)};
            g  = {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
            m  = model(s, g, 3'd0);
            send(s, g, 3'd0, m[31:0], m[36:32], 0, i < 2);
        end
        if (acc_log.size() == 3) begin
            chk("b2b_gap1", 64'(acc_log[1] - acc_log[0]), 64'd5);
            chk("b2b_gap2", 64'(acc_log[2] - acc_log[1]), 64'd5);
        end else begin
            chk("b2b_accepts", 64'(acc_log.size()), 64'd3);
        end

        // Random vectors under random backpressure.
        rand_bp = 1;
        for (int i = 0; i < 40; i++) begin
            s  = {1'b0, 8'($urandom_range(126, 117)), 23'($urandom)};
            g  = {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
            rm = 3'($urandom_range(1, 0));
            m  = model(s, g, rm);
            send(s, g, rm, m[31:0], m[36:32], 0, 0);
        end
        rand_bp = 0;
        @(posedge clk);
        #1 out_ready = 1'b1;

        // NaN propagation.
        send(32'h7fc00000, 32'h3f800000, 3'd0, 32'h7fc00000, 5'd0, 1, 0);
        repeat (6) @(posedge clk);
        #1;

        // Reset during MUL1 of a later transaction.
        send(32'h3f000000, 32'h40000000, 3'd0, 32'h3f000000, 5'd0, 0, 0);
        @(posedge clk);
        #1 rst_l = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 rst_l = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_out_valid", 64'(out_valid), 64'd0);
            chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        send(32'h3f400000, 32'h40000000, 3'd0, 32'h3ec00000, 5'd0, 0, 0);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
